detector_sequencer: RTL and testbench

Sequencer for the serial Moore sequence detector (W in, Z out). On a start request it clears the detector, serialises a parallel word onto W one bit per clock (LSB first), counts the cycles where the detector's Z is high, and reports the match count through a start/done handshake. It sits between a parallel host interface and the detector's W/Z/reset pins and owns the detector for the whole run.

---
 rtl/detector_sequencer.sv | 82 ++++++++
 tb/tb_detector_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/detector_sequencer.sv
// Sequencer that clears a serial Moore sequence detector, shifts a word onto W (LSB first),
// counts the cycles where Z is high and reports the count through a start/done handshake.
module detector_sequencer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             inputClk,
  input  logic             inputReset,
  input  logic             inputStart,
  input  logic [WIDTH-1:0] inputData,
  input  logic             inputZ,
  output logic             outputW,
  output logic             outputDetReset,
  output logic             outputBusy,
  output logic             outputDone,
  output logic [CNT_W-1:0] outputCount
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_count;

  // NOTE: every output is a pure decode of registered state, so no input reaches an output
  // combinationally and continuous assigns cannot infer a latch.
  assign outputW        = (r_state == SHIFT) && r_shift[0];
  assign outputDetReset = (r_state == CLEAR);
  assign outputBusy     = (r_state == CLEAR) || (r_state == SHIFT) || (r_state == DRAIN);
  assign outputDone     = (r_state == DONE);
  assign outputCount    = r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge inputClk) begin
    if (inputReset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (inputStart) begin
            r_shift <= inputData;
            r_count <= '0;
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_bit_cnt <= '0;
          r_state   <= SHIFT;
        end
        SHIFT: begin
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          // Z lags W by one edge, so the first SHIFT edge has nothing to sample yet.
          if ((r_bit_cnt != '0) && inputZ) r_count <= r_count + CNT_W'(1);
          if (r_bit_cnt == CNT_W'(WIDTH - 1)) r_state <= DRAIN;
        end
        DRAIN: begin
          if (inputZ) r_count <= r_count + CNT_W'(1);
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detector_sequencer.sv
// Bench for detector_sequencer driving a two-consecutive-ones Moore detector model;
// table-driven runs with a count scoreboard plus hand-written corner sequences.
module tb_detector_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             inputClk = 1'b0;
  logic             inputReset;
  logic             inputStart;
  logic [WIDTH-1:0] inputData;
  logic             inputZ;
  logic             outputW;
  logic             outputDetReset;
  logic             outputBusy;
  logic             outputDone;
  logic [CNT_W-1:0] outputCount;

  detector_sequencer #(.WIDTH(WIDTH)) dut (
    .inputClk       (inputClk),
    .inputReset     (inputReset),
    .inputStart     (inputStart),
    .inputData      (inputData),
    .inputZ         (inputZ),
    .outputW        (outputW),
    .outputDetReset (outputDetReset),
    .outputBusy     (outputBusy),
    .outputDone     (outputDone),
    .outputCount    (outputCount)
  );

  always #5 inputClk = ~inputClk;

  // Detector: 0 = no one seen, 1 = one 1 seen, 2 = two or more consecutive 1s (Z=1).
  logic [1:0] r_det;
  always_ff @(posedge inputClk) begin
    if (outputDetReset || inputReset) r_det <= 2'd0;
    else if (outputW)                 r_det <= (r_det == 2'd0) ? 2'd1 : 2'd2;
    else                              r_det <= 2'd0;
  end
  assign inputZ = (r_det == 2'd2);

  int n_tests = 0;
  int n_fail  = 0;
  int sb[$];

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int count_pairs(input logic [WIDTH-1:0] d);
    int n = 0;
    for (int i = 1; i < WIDTH; i++) if (d[i] && d[i-1]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge inputClk);
    #1;
  endtask

  // Called one step after an edge with the DUT idle; leaves the DUT idle one step after an edge.
  task automatic run_word(input logic [WIDTH-1:0] data, input int exp_count, input int poke_cycle);
    int dones = 0;
    logic [WIDTH-1:0] d;
    d = data;
    inputData  = data;
    inputStart = 1'b1;
    sb.push_back(exp_count);
    tick();
    inputStart = 1'b0;
    inputData  = ~data;
    for (int k = 1; k <= WIDTH + 3; k++) begin
      check($sformatf("busy c%0d", k), int'(outputBusy), (k <= WIDTH + 2) ? 1 : 0);
      check($sformatf("det_reset c%0d", k), int'(outputDetReset), (k == 1) ? 1 : 0);
      check($sformatf("w c%0d", k), int'(outputW),
            (k >= 2 && k <= WIDTH + 1) ? int'(d[k-2]) : 0);
      check($sformatf("done c%0d", k), int'(outputDone), (k == WIDTH + 3) ? 1 : 0);
      if (outputDone) begin
        dones++;
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else check($sformatf("count %02h", data), int'(outputCount), sb.pop_front());
      end
      inputStart = (k == poke_cycle);
      if (k == poke_cycle) inputData = '0;
      tick();
    end
    inputStart = 1'b0;
    check("done_pulses", dones, 1);
    check("idle_done", int'(outputDone), 0);
    check("idle_busy", int'(outputBusy), 0);
    check("count_held", int'(outputCount), exp_count);
  endtask

  typedef struct {
    logic [WIDTH-1:0] data;
    int               exp_count;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'hFF, 7};
    vecs[1] = '{8'h01, 0};  // right after 0xFF: stale detector state must be flushed
    vecs[2] = '{8'h00, 0};
    vecs[3] = '{8'hAA, 0};
    vecs[4] = '{8'h3C, 3};
    vecs[5] = '{8'h0F, 3};
    vecs[6] = '{8'hF0, 3};
    vecs[7] = '{8'hC3, 2};
    vecs[8] = '{8'h55, 0};
    vecs[9] = '{8'hFE, 6};

    inputReset = 1'b1;
    inputStart = 1'b0;
    inputData  = '0;
    tick();
    tick();
    check("rst_busy", int'(outputBusy), 0);
    check("rst_done", int'(outputDone), 0);
    check("rst_w", int'(outputW), 0);
    check("rst_det_reset", int'(outputDetReset), 0);
    check("rst_count", int'(outputCount), 0);
    inputReset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_done", int'(outputDone), 0);
      check("post_rst_busy", int'(outputBusy), 0);
    end

    for (int i = 0; i < 10; i++) run_word(vecs[i].data, vecs[i].exp_count, 0);

    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] r;
      r = WIDTH'($urandom_range(0, 255));
      run_word(r, count_pairs(r), 0);
    end

    // Start pulse with data 0x00 during SHIFT must be ignored.
    run_word(8'hFF, 7, 4);
    repeat (3) begin
      tick();
      check("no_restart_busy", int'(outputBusy), 0);
      check("no_restart_done", int'(outputDone), 0);
    end

    // Reset during SHIFT cycle 5 aborts the run without a done pulse.
    inputData  = 8'hFF;
    inputStart = 1'b1;
    tick();
    inputStart = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    check("pre_abort_busy", int'(outputBusy), 1);
    inputReset = 1'b1;
    tick();
    inputReset = 1'b0;
    check("abort_busy", int'(outputBusy), 0);
    check("abort_count", int'(outputCount), 0);
    check("abort_w", int'(outputW), 0);
    check("abort_done", int'(outputDone), 0);
    begin
      int dones = 0;
      for (int k = 0; k < WIDTH + 4; k++) begin
        if (outputDone) dones++;
        tick();
      end
      check("abort_no_done", dones, 0);
    end
    run_word(8'h3C, 3, 0);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
